// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every N_IN-bit input vector through a
// combinational DUT, holds each for HOLD_CYCLES clocks, and tallies mismatches.
module truth_table_sweeper #(
    parameter int                       N_IN        = 4,
    parameter logic [(2**N_IN)-1:0]     EXP_TABLE   = 16'h4644,
    parameter int                       HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_vld
);

    localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_IN-1:0] vec_out_q, vec_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N_IN:0]   err_count_q, err_count_d;
    logic [N_IN-1:0] first_err_vec_q, first_err_vec_d;
    logic            first_err_vld_q, first_err_vld_d;
    logic            mismatch;

    assign mismatch = (dut_out != EXP_TABLE[vec_out_q]);

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        vec_out_d       = vec_out_q;
        busy_d          = busy_q;
        done_d          = done_q;
        err_count_d     = err_count_q;
        first_err_vec_d = first_err_vec_q;
        first_err_vld_d = first_err_vld_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d         = APPLY;
                    hold_cnt_d      = '0;
                    vec_out_d       = '0;
                    busy_d          = 1'b1;
                    done_d          = 1'b0;
                    err_count_d     = '0;
                    first_err_vec_d = '0;
                    first_err_vld_d = 1'b0;
                end
            end
            APPLY: begin
                if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end else begin
                    // Sample edge: the compare, the tally and the DONE decision
                    // all happen together so a last-vector failure is counted before done.
                    if (mismatch) begin
                        err_count_d = err_count_q + (N_IN+1)'(1);
                        if (!first_err_vld_q) begin
                            first_err_vec_d = vec_out_q;
                            first_err_vld_d = 1'b1;
                        end
                    end
                    if (vec_out_q == VEC_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        vec_out_d  = vec_out_q + N_IN'(1);
                        hold_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            hold_cnt_q      <= '0;
            vec_out_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_count_q     <= '0;
            first_err_vec_q <= '0;
            first_err_vld_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            vec_out_q       <= vec_out_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_count_q     <= err_count_d;
            first_err_vec_q <= first_err_vec_d;
            first_err_vld_q <= first_err_vld_d;
        end
    end

    assign vec_out       = vec_out_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_count     = err_count_q;
    assign first_err_vec = first_err_vec_q;
    assign first_err_vld = first_err_vld_q;
    assign pass          = done_q && (err_count_q == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 4-input DUT model with injectable faults
// and a 2-input XOR instance with single-cycle hold.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2;
    logic [15:0] fault_mask;

    logic [3:0]  vec_out, first_err_vec;
    logic        dut_out, busy, done, pass, first_err_vld;
    logic [4:0]  err_count;

    logic [1:0]  vec2, first_err_vec2;
    logic        dut_out2, busy2, done2, pass2, first_err_vld2;
    logic [2:0]  err_count2;

    int total  = 0;
    int passed = 0;

    // Reference function: output is 1 exactly at inputs 2, 6, 9, 10, 14.
    function automatic logic ref_f(input int v);
        return logic'((v == 2) || (v == 6) || (v == 9) || (v == 10) || (v == 14));
    endfunction

    assign dut_out  = ref_f(int'(vec_out)) ^ fault_mask[vec_out];
    assign dut_out2 = vec2[1] ^ vec2[0];

    truth_table_sweeper u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_vec(first_err_vec),
        .first_err_vld(first_err_vld)
    );

    truth_table_sweeper #(.N_IN(2), .EXP_TABLE(4'b0110), .HOLD_CYCLES(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_out(dut_out2),
        .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .first_err_vec(first_err_vec2),
        .first_err_vld(first_err_vld2)
    );

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; fault_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({vec_out, busy, done, pass, err_count, first_err_vec, first_err_vld} !== 16'h0)
            $display("FAIL reset_outputs got=%h want=0",
                     {vec_out, busy, done, pass, err_count, first_err_vec, first_err_vld});
        else passed++;
        total++;
        if ({vec2, busy2, done2, pass2, err_count2, first_err_vec2, first_err_vld2} !== 11'h0)
            $display("FAIL reset_outputs2 got=%h want=0",
                     {vec2, busy2, done2, pass2, err_count2, first_err_vec2, first_err_vld2});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exact();
        int cyc;
        fault_mask = '0;
        pulse_start();
        total++;
        if (busy !== 1'b1 || vec_out !== 4'd0 || done !== 1'b0)
            $display("FAIL t1_start busy=%b vec=%0d done=%b want 1/0/0", busy, vec_out, done);
        else passed++;
        wait_done(cyc);
        total++;
        if (cyc !== 32) $display("FAIL t1_latency got=%0d want=32", cyc);
        else passed++;
        total++;
        if (err_count !== 5'd0 || pass !== 1'b1 || first_err_vld !== 1'b0 || busy !== 1'b0)
            $display("FAIL t1_result err=%0d pass=%b vld=%b busy=%b want 0/1/0/0",
                     err_count, pass, first_err_vld, busy);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || vec_out !== 4'hF || pass !== 1'b1)
            $display("FAIL t1_hold done=%b vec=%h pass=%b want 1/f/1", done, vec_out, pass);
        else passed++;
    endtask

    task automatic test_tied0();
        int cyc;
        for (int v = 0; v < 16; v++) fault_mask[v] = ref_f(v);
        pulse_start();
        wait_done(cyc);
        total++;
        if (cyc !== 32) $display("FAIL t2_latency got=%0d want=32", cyc);
        else passed++;
        total++;
        if (err_count !== 5'd5 || pass !== 1'b0 || first_err_vec !== 4'd2 || first_err_vld !== 1'b1)
            $display("FAIL t2_result err=%0d pass=%b fvec=%0d vld=%b want 5/0/2/1",
                     err_count, pass, first_err_vec, first_err_vld);
        else passed++;
    endtask

    task automatic test_last_vec();
        int         cyc;
        logic [4:0] prev_err;
        logic       prev_vld;
        fault_mask = 16'h8000;
        pulse_start();
        total++;
        if (err_count !== 5'd0 || first_err_vld !== 1'b0 || first_err_vec !== 4'd0)
            $display("FAIL t3_clear err=%0d vld=%b fvec=%0d want 0/0/0",
                     err_count, first_err_vld, first_err_vec);
        else passed++;
        cyc = 0; prev_err = '0; prev_vld = 1'b0;
        while (!done && cyc < 200) begin
            prev_err = err_count;
            prev_vld = first_err_vld;
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (cyc !== 32 || prev_err !== 5'd0 || prev_vld !== 1'b0)
            $display("FAIL t3_before_done cyc=%0d err=%0d vld=%b want 32/0/0", cyc, prev_err, prev_vld);
        else passed++;
        total++;
        if (err_count !== 5'd1 || first_err_vec !== 4'hF || first_err_vld !== 1'b1 || pass !== 1'b0)
            $display("FAIL t3_at_done err=%0d fvec=%h vld=%b pass=%b want 1/f/1/0",
                     err_count, first_err_vec, first_err_vld, pass);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        fault_mask = 16'h0001;
        pulse_start();
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({vec_out, busy, done, pass, err_count, first_err_vec, first_err_vld} !== 16'h0)
            $display("FAIL t4_reset got=%h want=0",
                     {vec_out, busy, done, pass, err_count, first_err_vec, first_err_vld});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        fault_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 4'd0)
            $display("FAIL t4_idle busy=%b done=%b vec=%0d want 0/0/0", busy, done, vec_out);
        else passed++;
        pulse_start();
        wait_done(cyc);
        total++;
        if (cyc !== 32 || pass !== 1'b1)
            $display("FAIL t4_resweep cyc=%0d pass=%b want 32/1", cyc, pass);
        else passed++;
    endtask

    task automatic test_start_held();
        int cyc;
        for (int v = 0; v < 16; v++) fault_mask[v] = ref_f(v);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(cyc);
        total++;
        if (cyc !== 32 || err_count !== 5'd5)
            $display("FAIL t5_no_restart cyc=%0d err=%0d want 32/5", cyc, err_count);
        else passed++;
        @(negedge clk);
        fault_mask = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || err_count !== 5'd0 || first_err_vld !== 1'b0 || vec_out !== 4'd0)
            $display("FAIL t5_reentry done=%b busy=%b err=%0d vld=%b vec=%0d want 0/1/0/0/0",
                     done, busy, err_count, first_err_vld, vec_out);
        else passed++;
        wait_done(cyc);
        total++;
        if (cyc !== 32 || pass !== 1'b1)
            $display("FAIL t5_second cyc=%0d pass=%b want 32/1", cyc, pass);
        else passed++;
    endtask

    task automatic test_random();
        int         cyc, exp_err, exp_first;
        logic [3:0] exp_fvec;
        for (int it = 0; it < 8; it++) begin
            fault_mask = 16'($urandom);
            if (it == 0) fault_mask = '0;
            if (it == 1) fault_mask = 16'hFFFF;
            exp_err = 0;
            exp_first = -1;
            for (int v = 0; v < 16; v++) begin
                if (fault_mask[v]) begin
                    exp_err++;
                    if (exp_first < 0) exp_first = v;
                end
            end
            exp_fvec = (exp_first < 0) ? 4'd0 : 4'(exp_first);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            pulse_start();
            wait_done(cyc);
            total++;
            if (cyc !== 32 || err_count !== 5'(exp_err) || pass !== (exp_err == 0) ||
                first_err_vld !== (exp_first >= 0) || first_err_vec !== exp_fvec)
                $display("FAIL rand_%0d mask=%h cyc=%0d err=%0d pass=%b vld=%b fvec=%0d want 32/%0d/%b/%b/%0d",
                         it, fault_mask, cyc, err_count, pass, first_err_vld, first_err_vec,
                         exp_err, exp_err == 0, exp_first >= 0, exp_fvec);
            else passed++;
        end
    endtask

    task automatic test_small();
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        total++;
        if (vec2 !== 2'd0 || busy2 !== 1'b1 || done2 !== 1'b0)
            $display("FAIL t6_start vec=%0d busy=%b done=%b want 0/1/0", vec2, busy2, done2);
        else passed++;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (vec2 !== 2'(i) || done2 !== 1'b0)
                $display("FAIL t6_step%0d vec=%0d done=%b want %0d/0", i, vec2, done2, i);
            else passed++;
        end
        @(posedge clk);
        #1;
        total++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || vec2 !== 2'd3 || pass2 !== 1'b1 || err_count2 !== 3'd0)
            $display("FAIL t6_done done=%b busy=%b vec=%0d pass=%b err=%0d want 1/0/3/1/0",
                     done2, busy2, vec2, pass2, err_count2);
        else passed++;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout total=%0d passed=%0d", total, passed);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exact();
        test_tied0();
        test_last_vec();
        test_reset_mid();
        test_start_held();
        test_random();
        test_small();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
